bram_resp_mailbox: RTL and testbench

Slave-side responder for the MBRAM master port of the Montgomery multiplier top wrapper. It owns a word-organised operand/result memory that the host fills through a load stream and drains through an unload stream. Between those two phases it serves the multiplier's byte-addressed BRAM accesses, pulses the multiplier start and waits for its done. It sits between the processor-side streaming logic and the multiplier wrapper, replacing a Block RAM plus controller.

---
 rtl/bram_resp_mailbox.sv | 164 ++++++++++++++++
 tb/tb_bram_resp_mailbox.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bram_resp_mailbox.sv
// Mailbox memory that stands in for the multiplier's Block RAM: host loads operands, multiplier runs
// against the BRAM port, host unloads the result. Optional watchdog: define MAILBOX_TIMEOUT_EN.
module bram_resp_mailbox #(
  parameter int WIDTH          = 1024,
  parameter int S              = (WIDTH + 1) / 17 + 1,
  parameter int DEPTH          = 256,
  parameter int LOAD_WORDS     = 3 * S,
  parameter int RESULT_BASE    = 3 * S,
  parameter int RESULT_WORDS   = S,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic        clock_i,
  input  logic        reset_i,
  input  logic [31:0] BRAM_addr_i,
  input  logic [31:0] BRAM_din_i,
  input  logic [3:0]  BRAM_we_i,
  input  logic        BRAM_en_i,
  output logic [31:0] BRAM_dout_o,
  input  logic        go_i,
  input  logic        load_valid_i,
  output logic        load_ready_o,
  input  logic [31:0] load_data_i,
  output logic        start_o,
  input  logic        done_i,
  output logic        unload_valid_o,
  input  logic        unload_ready_i,
  output logic [31:0] unload_data_o,
  output logic        busy_o,
  output logic        err_o
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_LOAD   = 2'd1;
  localparam logic [1:0] ST_RUN    = 2'd2;
  localparam logic [1:0] ST_UNLOAD = 2'd3;

  logic [1:0]    r_state;
  logic [CW-1:0] r_cnt;
  logic          r_start;
  logic          r_err;
  logic [31:0]   r_dout;
  logic [31:0]   r_pf_data;
  logic          r_pf_vld;
  logic [31:0]   r_out_data;
  logic          r_out_vld;
  logic [31:0]   r_mem [DEPTH];

  logic [29:0]   w_bidx;
  logic [AW-1:0] w_bram_a;
  logic          w_bram_bad;
  logic          w_bram_acc;
  logic          w_bram_wr;
  logic          w_load_beat;
  logic          w_last_load;
  logic          w_out_take;
  logic          w_pf_take;
  logic          w_issue;
  logic [AW-1:0] w_ul_a;
  logic          w_ul_last;

  assign w_bidx      = BRAM_addr_i[31:2];
  assign w_bram_a    = w_bidx[AW-1:0];
  assign w_bram_bad  = (BRAM_addr_i[1:0] != 2'b00) || (w_bidx >= 30'(DEPTH));
  assign w_bram_acc  = (r_state == ST_RUN) && BRAM_en_i;
  assign w_bram_wr   = w_bram_acc && !w_bram_bad;
  assign w_load_beat = (r_state == ST_LOAD) && load_valid_i;
  assign w_last_load = w_load_beat && (r_cnt == CW'(LOAD_WORDS - 1));

  // Two-deep unload pipe: prefetch register feeds the output register, so a stalled
  // output still lets the next memory read land and ready-high streams one word per cycle.
  assign w_out_take  = !r_out_vld || unload_ready_i;
  assign w_pf_take   = !r_pf_vld || w_out_take;
  assign w_issue     = (r_state == ST_UNLOAD) && w_pf_take && (r_cnt != CW'(RESULT_WORDS));
  assign w_ul_a      = AW'(RESULT_BASE) + r_cnt[AW-1:0];
  assign w_ul_last   = (r_state == ST_UNLOAD) && r_out_vld && unload_ready_i && !r_pf_vld &&
                       (r_cnt == CW'(RESULT_WORDS));

  // Contents deliberately survive reset.
  always_ff @(posedge clock_i) begin
    if (w_load_beat) begin
      r_mem[r_cnt[AW-1:0]] <= load_data_i;
    end else if (w_bram_wr) begin
      for (int b = 0; b < 4; b++)
        if (BRAM_we_i[b]) r_mem[w_bram_a][8*b +: 8] <= BRAM_din_i[8*b +: 8];
    end
  end

`ifdef MAILBOX_TIMEOUT_EN
  logic [31:0] r_to_cnt;
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i)                  r_to_cnt <= '0;
    else if (r_state != ST_RUN)   r_to_cnt <= '0;
    else                          r_to_cnt <= r_to_cnt + 32'd1;
  end
`endif

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_start    <= 1'b0;
      r_err      <= 1'b0;
      r_dout     <= '0;
      r_pf_data  <= '0;
      r_pf_vld   <= 1'b0;
      r_out_data <= '0;
      r_out_vld  <= 1'b0;
    end else begin
      r_start <= w_last_load;

      if (w_bram_acc) r_dout <= w_bram_bad ? 32'd0 : r_mem[w_bram_a];

      if (w_issue) r_pf_data <= r_mem[w_ul_a];
      if (w_issue)         r_pf_vld <= 1'b1;
      else if (w_out_take) r_pf_vld <= 1'b0;

      if (w_out_take) begin
        r_out_vld <= r_pf_vld;
        if (r_pf_vld) r_out_data <= r_pf_data;
      end

      case (r_state)
        ST_IDLE: if (go_i) begin
          r_state <= ST_LOAD;
          r_cnt   <= '0;
          r_err   <= 1'b0;
        end
        ST_LOAD: if (w_load_beat) begin
          r_cnt <= w_last_load ? '0 : r_cnt + CW'(1);
          if (w_last_load) r_state <= ST_RUN;
        end
        ST_RUN: begin
          if (done_i) begin
            r_state <= ST_UNLOAD;
            r_cnt   <= '0;
          end
`ifdef MAILBOX_TIMEOUT_EN
          else if (r_to_cnt == 32'(TIMEOUT_CYCLES - 1)) begin
            r_state <= ST_IDLE;
            r_err   <= 1'b1;
          end
`endif
        end
        default: begin
          if (w_issue)   r_cnt   <= r_cnt + CW'(1);
          if (w_ul_last) r_state <= ST_IDLE;
        end
      endcase

      // A bad access in the same cycle as an accepted go still leaves the flag set.
      if (BRAM_en_i && ((r_state != ST_RUN) || w_bram_bad)) r_err <= 1'b1;
    end
  end

  assign BRAM_dout_o    = r_dout;
  assign load_ready_o   = (r_state == ST_LOAD);
  assign start_o        = r_start;
  assign unload_valid_o = r_out_vld;
  assign unload_data_o  = r_out_data;
  assign busy_o         = (r_state != ST_IDLE);
  assign err_o          = r_err;
endmodule

// File: tb/tb_bram_resp_mailbox.sv
// Scoreboard bench for bram_resp_mailbox: results written by the fake master are queued and
// matched against the unload stream.
module tb_bram_resp_mailbox;
  localparam int WIDTH = 1024;
  localparam int S     = (WIDTH + 1) / 17 + 1;
  localparam int DEPTH = 256;
  localparam int LW    = 3 * S;
  localparam int RB    = 3 * S;
  localparam int RW    = S;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] addr = '0, din = '0;
  logic [3:0]  we = '0;
  logic        en = 1'b0;
  logic [31:0] dout;
  logic        go = 1'b0;
  logic        load_valid = 1'b0;
  logic        load_ready;
  logic [31:0] load_data = '0;
  logic        start;
  logic        done = 1'b0;
  logic        unload_valid;
  logic        unload_ready = 1'b0;
  logic [31:0] unload_data;
  logic        busy, err;

  int          n_checks = 0;
  int          n_fail = 0;
  logic [31:0] sb_q[$];

  always #5 clk = ~clk;

  bram_resp_mailbox dut (
    .clock_i(clk), .reset_i(rst),
    .BRAM_addr_i(addr), .BRAM_din_i(din), .BRAM_we_i(we), .BRAM_en_i(en), .BRAM_dout_o(dout),
    .go_i(go), .load_valid_i(load_valid), .load_ready_o(load_ready), .load_data_i(load_data),
    .start_o(start), .done_i(done),
    .unload_valid_o(unload_valid), .unload_ready_i(unload_ready), .unload_data_o(unload_data),
    .busy_o(busy), .err_o(err)
  );

  task automatic do_go();
    @(posedge clk); #1; go = 1'b1;
    @(posedge clk); #1; go = 1'b0;
  endtask

  task automatic do_load();
    for (int i = 0; i < LW; i++) begin
      load_valid = 1'b1; load_data = i;
      @(posedge clk); #1;
    end
    load_valid = 1'b0;
  endtask

  task automatic bram_op(input logic [31:0] a, input logic [31:0] d, input logic [3:0] w,
                         output logic [31:0] q);
    en = 1'b1; addr = a; din = d; we = w;
    @(posedge clk); #1;
    en = 1'b0; we = '0;
    q = dout;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({dout, load_ready, start, unload_valid, unload_data, busy, err} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got dout=%h lr=%b st=%b uv=%b ud=%h busy=%b err=%b want all 0",
               dout, load_ready, start, unload_valid, unload_data, busy, err);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_idle_busy: got %b want 0", busy); end
  endtask

  task automatic test_idle_access();
    logic [31:0] q;
    done = 1'b1;
    bram_op(32'h0, 32'hDEADBEEF, 4'hF, q);
    done = 1'b0;
    n_checks++;
    if (err !== 1'b1) begin n_fail++; $display("FAIL idle_access_err: got %b want 1", err); end
    n_checks++;
    if (q !== 32'd0) begin n_fail++; $display("FAIL idle_access_dout: got %h want 0", q); end
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL idle_done_ignored: busy %b want 0", busy); end
  endtask

  task automatic test_full_sequence();
    logic [31:0] q, exp;
    int          n;
    do_go();
    n_checks++;
    if ({busy, load_ready, err} !== 3'b110) begin
      n_fail++; $display("FAIL go_accept: got busy/ready/err=%b want 110", {busy, load_ready, err});
    end
    do_load();
    n_checks++;
    if (start !== 1'b1) begin n_fail++; $display("FAIL start_first_cycle: got %b want 1", start); end
    n = 0;
    repeat (4) begin @(posedge clk); #1; n += int'(start); end
    n_checks++;
    if (n != 0 || load_ready !== 1'b0) begin
      n_fail++; $display("FAIL start_single_pulse: extra pulses %0d ready %b want 0 0", n, load_ready);
    end

    bram_op(32'h2D8, 32'h0, 4'h0, q);
    n_checks++;
    if (q !== 32'd182) begin n_fail++; $display("FAIL read_word182: got %h want %h", q, 32'd182); end

    bram_op(32'h14, 32'h11223344, 4'hF, q);
    n_checks++;
    if (q !== 32'd5) begin n_fail++; $display("FAIL read_first_full: got %h want %h", q, 32'd5); end
    bram_op(32'h14, 32'hAABBCCDD, 4'b0101, q);
    n_checks++;
    if (q !== 32'h11223344) begin n_fail++; $display("FAIL read_first_be: got %h want 11223344", q); end
    bram_op(32'h14, 32'h0, 4'h0, q);
    n_checks++;
    if (q !== 32'h11BB33DD) begin n_fail++; $display("FAIL byte_enable: got %h want 11bb33dd", q); end
    n_checks++;
    if (err !== 1'b0) begin n_fail++; $display("FAIL no_err_yet: got %b want 0", err); end

    bram_op(32'h2, 32'hFFFFFFFF, 4'hF, q);
    n_checks++;
    if (err !== 1'b1 || q !== 32'd0) begin
      n_fail++; $display("FAIL misaligned: err %b dout %h want 1 00000000", err, q);
    end
    bram_op(32'h0, 32'h0, 4'h0, q);
    n_checks++;
    if (q !== 32'd0) begin n_fail++; $display("FAIL misaligned_nowrite: word0 %h want 0", q); end
    bram_op(32'h2D8, 32'h0, 4'h0, q);
    bram_op(32'(4 * DEPTH), 32'h12345678, 4'hF, q);
    n_checks++;
    if (q !== 32'd0) begin n_fail++; $display("FAIL out_of_range_dout: got %h want 0", q); end

    for (int i = 0; i < RW; i++) begin
      bram_op(32'(4 * (RB + i)), 32'h1000 + 32'(4 * i), 4'hF, q);
      sb_q.push_back(32'h1000 + 32'(4 * i));
    end

    unload_ready = 1'b1;
    done = 1'b1;
    @(posedge clk); #1; done = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if (unload_valid !== 1'b0) begin n_fail++; $display("FAIL unload_latency_early: valid %b want 0", unload_valid); end
    for (int i = 0; i < RW; i++) begin
      @(posedge clk); #1;
      exp = sb_q.pop_front();
      n_checks++;
      if (unload_valid !== 1'b1 || unload_data !== exp) begin
        n_fail++;
        $display("FAIL unload_stream[%0d]: valid %b data %h want 1 %h", i, unload_valid, unload_data, exp);
      end
    end
    @(posedge clk); #1;
    n_checks++;
    if ({busy, unload_valid, err} !== 3'b001) begin
      n_fail++; $display("FAIL unload_end: busy/valid/err %b want 001", {busy, unload_valid, err});
    end
    unload_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    logic [31:0] q, exp;
    logic [3:0]  pat;
    int          cyc;
    pat = 4'b1001;
    do_go();
    n_checks++;
    if (err !== 1'b0) begin n_fail++; $display("FAIL go_clears_err: got %b want 0", err); end
    do_load();
    for (int i = 0; i < RW; i++) begin
      bram_op(32'(4 * (RB + i)), 32'h5000_0000 + 32'(7 * i), 4'hF, q);
      sb_q.push_back(32'h5000_0000 + 32'(7 * i));
    end
    done = 1'b1;
    @(posedge clk); #1; done = 1'b0;
    cyc = 0;
    while (sb_q.size() > 0 && cyc < 600) begin
      unload_ready = pat[cyc % 4];
      if (unload_valid) begin
        exp = sb_q[0];
        n_checks++;
        if (unload_data !== exp) begin
          n_fail++; $display("FAIL bp_data cyc %0d: got %h want %h", cyc, unload_data, exp);
        end
        if (unload_ready) void'(sb_q.pop_front());
      end
      @(posedge clk); #1;
      cyc++;
    end
    unload_ready = 1'b0;
    n_checks++;
    if (cyc >= 600) begin n_fail++; $display("FAIL bp_timeout: %0d words left want 0", sb_q.size()); end
    n_checks++;
    if ({busy, unload_valid} !== 2'b00) begin
      n_fail++; $display("FAIL bp_end: busy/valid %b want 00", {busy, unload_valid});
    end
  endtask

  task automatic test_reset_mid_unload();
    int cyc;
    do_go();
    do_load();
    unload_ready = 1'b0;
    done = 1'b1;
    @(posedge clk); #1; done = 1'b0;
    cyc = 0;
    while (!unload_valid && cyc < 10) begin @(posedge clk); #1; cyc++; end
    n_checks++;
    if (unload_valid !== 1'b1) begin n_fail++; $display("FAIL mid_unload_reach: valid %b want 1", unload_valid); end
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if ({busy, unload_valid, unload_data, start, load_ready, dout, err} !== '0) begin
      n_fail++; $display("FAIL mid_unload_reset: busy %b uv %b ud %h dout %h want all 0",
                         busy, unload_valid, unload_data, dout);
    end
    @(posedge clk); #1; rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({busy, unload_valid} !== 2'b00) begin
      n_fail++; $display("FAIL post_reset_idle: busy/valid %b want 00", {busy, unload_valid});
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_idle_access();
    test_full_sequence();
    test_backpressure();
    test_reset_mid_unload();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
